// File: rtl/regfile_seq_ctrl_if.sv
// Control bundle between the instruction sequencer and the register-file datapath.
// Purely structural; no latency of its own.
// No backpressure: start is a level sampled by the sequencer, strobes are unconditional.
interface regfile_seq_ctrl_if #(
    parameter int RN = 3,
    parameter int IW = 16
);
    logic          s;
    logic [IW-1:0] instr;
    logic          w;
    logic [RN-1:0] readnum;
    logic [RN-1:0] writenum;
    logic          write;
    logic          loada;
    logic          loadb;
    logic          loadc;
    logic          loads;
    logic          asel;
    logic          vsel;
    logic [1:0]    shift;
    logic [1:0]    alu_op;
    logic          illegal;

    // Instruction-register side: issues start and instruction, watches the strobes.
    modport master (
        output s, instr,
        input  w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, vsel, shift, alu_op, illegal
    );

    // Sequencer side.
    modport slave (
        input  s, instr,
        output w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, vsel, shift, alu_op, illegal
    );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Moore sequencer driving the 8x16 register file / ALU datapath, one instruction at a time.
// Latency: MOV imm 2, MOV reg/MVN/CMP 4, ADD/AND 5, illegal 1 busy cycles after start.
// Start is accepted only while w=1; s is ignored while busy (caller must wait for w).
module regfile_seq_ctrl #(
    parameter int RN = 3,
    parameter int IW = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    regfile_seq_ctrl_if.slave  bus
);
    localparam logic [2:0] ST_WAIT      = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_WRITE_IMM = 3'd2;
    localparam logic [2:0] ST_GET_A     = 3'd3;
    localparam logic [2:0] ST_GET_B     = 3'd4;
    localparam logic [2:0] ST_ALU       = 3'd5;
    localparam logic [2:0] ST_WRITE_REG = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          illegal_q, illegal_d;

    // Instruction fields, always taken from the latched copy so late instr changes are harmless.
    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [RN-1:0] rn, rd, rm;
    logic          is_cmp;
    logic          zero_a;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign rm     = ir_q[2:0];
    assign is_cmp = (opcode == 3'b101) && (op == 2'b01);
    // MOV Rd,Rm and MVN pass B through the ALU, so A is forced to zero.
    assign zero_a = (opcode == 3'b110) || ((opcode == 3'b101) && (op == 2'b11));

    // Next-state, instruction latch and sticky illegal flag.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_WAIT: begin
                if (bus.s) begin
                    ir_d      = bus.instr;
                    illegal_d = 1'b0;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case ({opcode, op})
                    5'b110_10:                       state_d = ST_WRITE_IMM;
                    5'b110_00, 5'b101_11:            state_d = ST_GET_B;
                    5'b101_00, 5'b101_01, 5'b101_10: state_d = ST_GET_A;
                    default: begin
                        state_d   = ST_WAIT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_WRITE_IMM: state_d = ST_WAIT;
            ST_GET_A:     state_d = ST_GET_B;
            ST_GET_B:     state_d = ST_ALU;
            ST_ALU:       state_d = is_cmp ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: state_d = ST_WAIT;
            default:      state_d = ST_WAIT;
        endcase
    end

    // State registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_WAIT;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    logic          w_o, write_o, loada_o, loadb_o, loadc_o, loads_o, asel_o, vsel_o;
    logic [RN-1:0] readnum_o, writenum_o;
    logic [1:0]    shift_o, alu_op_o;

    // Moore output decode: every strobe is a function of state and the latched instruction.
    always_comb begin
        w_o        = 1'b0;
        readnum_o  = '0;
        writenum_o = '0;
        write_o    = 1'b0;
        loada_o    = 1'b0;
        loadb_o    = 1'b0;
        loadc_o    = 1'b0;
        loads_o    = 1'b0;
        asel_o     = 1'b0;
        vsel_o     = 1'b0;
        shift_o    = 2'b00;
        alu_op_o   = 2'b00;
        case (state_q)
            ST_WAIT: w_o = 1'b1;
            ST_WRITE_IMM: begin
                writenum_o = rn;
                vsel_o     = 1'b1;
                write_o    = 1'b1;
            end
            ST_GET_A: begin
                readnum_o = rn;
                loada_o   = 1'b1;
            end
            ST_GET_B: begin
                readnum_o = rm;
                loadb_o   = 1'b1;
            end
            ST_ALU: begin
                shift_o  = ir_q[4:3];
                alu_op_o = op;
                asel_o   = zero_a;
                loadc_o  = !is_cmp;
                loads_o  = is_cmp;
            end
            ST_WRITE_REG: begin
                writenum_o = rd;
                write_o    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.w        = w_o;
    assign bus.readnum  = readnum_o;
    assign bus.writenum = writenum_o;
    assign bus.write    = write_o;
    assign bus.loada    = loada_o;
    assign bus.loadb    = loadb_o;
    assign bus.loadc    = loadc_o;
    assign bus.loads    = loads_o;
    assign bus.asel     = asel_o;
    assign bus.vsel     = vsel_o;
    assign bus.shift    = shift_o;
    assign bus.alu_op   = alu_op_o;
    assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Bench for regfile_seq_ctrl: per-cycle comparison against an instruction-level schedule
// model, plus literal expectations for the directed instructions.
module tb_regfile_seq_ctrl;
    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       vsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       illegal;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    regfile_seq_ctrl_if bus ();

    regfile_seq_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic obs_t sample();
        obs_t o;
        o.w = bus.w; o.readnum = bus.readnum; o.writenum = bus.writenum;
        o.write = bus.write; o.loada = bus.loada; o.loadb = bus.loadb;
        o.loadc = bus.loadc; o.loads = bus.loads; o.asel = bus.asel;
        o.vsel = bus.vsel; o.shift = bus.shift; o.alu_op = bus.alu_op;
        o.illegal = bus.illegal;
        return o;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- model: list of expected busy cycles per instruction ----------------
    obs_t sched[$];
    bit   m_illegal = 1'b0;

    function automatic obs_t blank();
        obs_t e;
        e = '0;
        return e;
    endfunction

    task automatic plan(input logic [15:0] iv);
        obs_t e;
        logic [4:0] key;
        bit bad;
        key = {iv[15:13], iv[12:11]};
        bad = 1'b0;
        sched.push_back(blank());                               // decode
        case (key)
            5'b110_10: begin
                e = blank(); e.writenum = iv[10:8]; e.vsel = 1; e.write = 1; sched.push_back(e);
            end
            5'b110_00, 5'b101_00, 5'b101_01, 5'b101_10, 5'b101_11: begin
                if (key != 5'b110_00 && key != 5'b101_11) begin
                    e = blank(); e.readnum = iv[10:8]; e.loada = 1; sched.push_back(e);
                end
                e = blank(); e.readnum = iv[2:0]; e.loadb = 1; sched.push_back(e);
                e = blank(); e.shift = iv[4:3]; e.alu_op = iv[12:11];
                e.asel  = (key == 5'b110_00) || (key == 5'b101_11);
                e.loads = (key == 5'b101_01);
                e.loadc = (key != 5'b101_01);
                sched.push_back(e);
                if (key != 5'b101_01) begin
                    e = blank(); e.writenum = iv[7:5]; e.write = 1; sched.push_back(e);
                end
            end
            default: bad = 1'b1;
        endcase
        m_illegal = bad;
    endtask

    function automatic obs_t expected_now();
        obs_t e;
        if (sched.size() > 0) return sched[0];
        e = blank(); e.w = 1; e.illegal = m_illegal;
        return e;
    endfunction

    // Model advance: one schedule step per clock, new instruction only when idle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sched.delete();
            m_illegal = 1'b0;
        end else if (sched.size() > 0) begin
            void'(sched.pop_front());
        end else if (bus.s === 1'b1) begin
            plan(bus.instr);
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        obs_t a, e;
        a = sample();
        e = expected_now();
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL cycle_model @%0t: got %h expected %h", $time, a, e);
        end
    end

    // ---------------- directed stimulus ----------------
    obs_t rec[32];
    int   busy;
    int   writes;

    task automatic step();
        @(negedge clk); #1;
    endtask

    // Caller must be in WAIT at negedge+1; returns at negedge+1 in DECODE.
    task automatic issue(input logic [15:0] iv);
        bus.s = 1'b1; bus.instr = iv;
        step();
        bus.s = 1'b0;
    endtask

    task automatic collect(input bit noisy);
        busy = 0; writes = 0;
        while (!bus.w && busy < 20) begin
            rec[busy] = sample();
            if (bus.write) writes++;
            busy++;
            if (noisy) begin
                bus.s = ~bus.s;
                bus.instr = bus.instr ^ 16'h5A5A;
            end
            step();
        end
        if (busy >= 20) check("busy_timeout", busy, 0);
    endtask

    initial begin
        obs_t o;
        bus.s = 1'b0; bus.instr = 16'h0000;
        #1;
        o = sample();
        check("reset_w", o.w, 1);
        check("reset_strobes", int'(o), int'(obs_t'(19'h40000)));
        step(); step();
        reset_n = 1'b1;
        step();

        // MOV R3,#5
        issue(16'hD305);
        collect(0);
        check("movi_busy", busy, 2);
        check("movi_decode_w", rec[0].w, 0);
        check("movi_write", rec[1].write, 1);
        check("movi_writenum", rec[1].writenum, 3);
        check("movi_vsel", rec[1].vsel, 1);
        step();

        // ADD R2,R1,R0
        issue(16'hA140);
        collect(0);
        check("add_busy", busy, 5);
        check("add_geta", {rec[1].readnum, rec[1].loada}, {3'd1, 1'b1});
        check("add_getb", {rec[2].readnum, rec[2].loadb}, {3'd0, 1'b1});
        check("add_alu", {rec[3].alu_op, rec[3].loadc}, {2'b00, 1'b1});
        check("add_wr", {rec[4].writenum, rec[4].write}, {3'd2, 1'b1});
        check("add_writes", writes, 1);

        // CMP R1,R0
        issue(16'hA900);
        collect(0);
        check("cmp_busy", busy, 4);
        check("cmp_alu", {rec[3].alu_op, rec[3].loads, rec[3].loadc}, {2'b01, 1'b1, 1'b0});
        check("cmp_writes", writes, 0);

        // MVN R4,R7
        issue(16'hB887);
        collect(0);
        check("mvn_busy", busy, 4);
        check("mvn_getb", rec[1].readnum, 7);
        check("mvn_alu", {rec[2].asel, rec[2].alu_op}, {1'b1, 2'b11});
        check("mvn_wr", rec[3].writenum, 4);

        // Illegal opcode, then a valid MOV R5,R1 clears the flag.
        issue(16'h0000);
        collect(0);
        check("ill_busy", busy, 1);
        check("ill_writes", writes, 0);
        check("ill_flag", bus.illegal, 1);
        step();
        check("ill_sticky", bus.illegal, 1);
        issue(16'hC0A1);
        collect(0);
        check("movr_clears_ill", rec[0].illegal, 0);
        check("movr_busy", busy, 4);
        check("movr_alu_asel", rec[2].asel, 1);

        // AND R1,R2,R3 (model-checked path)
        issue(16'hB223);
        collect(0);
        check("and_busy", busy, 5);

        // ADD R6,R3,R5 LSL-code 01 with s toggling and instr scrambling while busy.
        issue(16'hA3CD);
        collect(1);
        check("noisy_busy", busy, 5);
        check("noisy_rn", rec[1].readnum, 3);
        check("noisy_rm", rec[2].readnum, 5);
        check("noisy_shift", rec[3].shift, 1);
        check("noisy_rd", rec[4].writenum, 6);
        // Hold s high in the single WAIT cycle: MOV R3,#5 follows immediately.
        bus.s = 1'b1; bus.instr = 16'hD305;
        step();
        check("b2b_started", bus.w, 0);
        collect(0);
        bus.s = 1'b0;
        check("b2b_busy", busy, 2);
        check("b2b_writenum", rec[1].writenum, 3);
        step();

        // Reset asserted in GET_B of an ADD.
        issue(16'hA140);
        step(); step();
        check("rst_pre_getb", {bus.readnum, bus.loadb}, {3'd0, 1'b1});
        reset_n = 1'b0;
        #1;
        check("rst_w", bus.w, 1);
        check("rst_write", bus.write, 0);
        check("rst_loads", {bus.loada, bus.loadb, bus.loadc, bus.loads}, 0);
        step(); step();
        reset_n = 1'b1;
        step(); step();
        check("rst_idle", bus.w, 1);
        check("rst_idle_write", bus.write, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
- Moore FSM that sequences the 8x16 register file and its ALU datapath for one instruction at a time.
- Latches a 16-bit instruction on a start handshake, decodes it, and drives the control strobes cycle by cycle:
  - register-file read/write indices and write enable;
  - A/B/C/status load enables, operand selects and ALU op.
- Sits between the instruction register and the datapath. Asserts w when idle/finished.

Parameters:
- RN, 3, register index width (8 registers); only default supported.
- IW, 16, instruction width; only default supported.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- s  input  1  start; sampled only in WAIT
- instr  input  IW  instruction: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], shift[4:3], Rm[2:0]
- w  output  1  idle/done; 1 only in WAIT
- readnum  output  RN  register file read index
- writenum  output  RN  register file write index
- write  output  1  register file write enable
- loada, loadb, loadc, loads  output  1 each  datapath A, B, C and status register load enables
- asel  output  1  1 = A operand forced to 0
- vsel  output  1  write-data mux: 0 = datapath C, 1 = sign-extended instr[7:0]
- shift  output  2  shifter control for B
- alu_op  output  2  ALU op: 00 ADD, 01 SUB (CMP), 10 AND, 11 NOT B
- illegal  output  1  sticky unsupported-opcode flag

Behaviour:
- Reset (async, reset_n=0):
  - state=WAIT; internal instr register=0; illegal=0; w=1.
  - All other outputs 0.
  - Reset mid-instruction aborts immediately; no partial write completes after reset asserts.
- WAIT:
  - w=1.
  - On posedge with s=1: latch instr into ir, clear illegal, go to DECODE.
  - s ignored in every other state.
  - instr changes after the latch have no effect.
- All outputs are decoded from state and ir only (Moore). Defaults are 0 in every state unless listed.
- State outputs:
  - DECODE: all strobes 0.
  - WRITE_IMM: writenum=Rn, vsel=1, write=1.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - ALU: shift=ir[4:3], alu_op=op; asel=1 for MOV-reg/MVN; loadc=1 except CMP; loads=1 only for CMP.
  - WRITE_REG: writenum=Rd, vsel=0, write=1.
- Decode and paths (opcode, op):
  - 110,10 MOV Rn,#imm8: DECODE -> WRITE_IMM -> WAIT.
  - 110,00 MOV Rd,Rm{sh}: DECODE -> GET_B -> ALU (alu_op=00, asel=1) -> WRITE_REG -> WAIT.
  - 101,00 ADD / 101,10 AND: DECODE -> GET_A -> GET_B -> ALU -> WRITE_REG -> WAIT.
  - 101,01 CMP: DECODE -> GET_A -> GET_B -> ALU (loads=1, loadc=0) -> WAIT. No register write.
  - 101,11 MVN: DECODE -> GET_B -> ALU (asel=1) -> WRITE_REG -> WAIT.
  - Any other opcode/op pair: DECODE -> WAIT, illegal=1. illegal holds until the next accepted start.
- Latency in cycles with w=0:
  - MOV imm: 2.
  - MOV reg, MVN, CMP: 4.
  - ADD, AND: 5.
  - Illegal: 1.
- Back-to-back: s held high in WAIT starts the next instruction on the edge that leaves WAIT. No idle gap beyond the single WAIT cycle.
- write is asserted in at most one cycle per instruction.
- readnum and writenum are 0 in states that do not use them. Verification checks this.

Test Plan:
- Reset: reset_n=0 mid-ADD (in GET_B) -> same cycle: w=1, write=0, all loads=0; after release FSM sits in WAIT.
- MOV R3,#5 (instr=0xD305, s=1 one cycle):
  - DECODE: w=0.
  - WRITE_IMM: write=1, writenum=3, vsel=1.
  - Then w=1. Exactly 2 busy cycles.
- ADD R2,R1,R0 (0xA140):
  - GET_A readnum=1 loada=1.
  - GET_B readnum=0 loadb=1.
  - ALU alu_op=00 loadc=1.
  - WRITE_REG writenum=2 write=1.
  - 5 busy cycles.
- CMP R1,R0 (0xA900) -> ALU cycle: alu_op=01, loads=1, loadc=0; write never asserted; 4 busy cycles.
- MVN R4,R7 (0xB887) -> GET_B readnum=7; ALU asel=1 alu_op=11; WRITE_REG writenum=4. Then issue 0x0000 -> 1 busy cycle, illegal=1, write never 1. Next valid start clears illegal.
- s toggled high every cycle during an ADD, and instr changed after the latch -> ignored. Sequence and indices match the latched instr. With s held high, a back-to-back MOV imm starts after one WAIT cycle.
